gp0_wr_burst_to_stream: RTL
===========================

// Module: gp0_wr_burst_to_stream
// PURPOSE
//  Write-side consumer for the PS GP0 AXI3 slave port: accepts AW/W bursts from M_AXI_GP0, returns B
//  responses, and pushes the accepted payload words into a FIFO. The FIFO drains as a ready/valid
//  word stream into the input-layer datapath. One write transaction is in flight at a time; no read path.
// PARAMETERS
//  FIFO_DEPTH  16           stream FIFO entries (power of 2, >= 16, so one full burst always fits)
//  BASE_ADDR   32'h4000_0000 window base; accept when awaddr[31:WIN_BITS]==BASE_ADDR[31:WIN_BITS]
//  WIN_BITS    16           window size = 2**WIN_BITS bytes
// PORTS
//  clk                   in   1   single clock for AXI and stream sides
//  rst_n                 in   1   asynchronous active-low reset
//  M_AXI_GP0_awaddr      in   32  burst start address (window check only)
//  M_AXI_GP0_awlen       in   4   beats-1 (AXI3, 1..16 beats)
//  M_AXI_GP0_awsize      in   3   must be 3'b010 (4 bytes)
//  M_AXI_GP0_awburst     in   2   must be 2'b01 (INCR)
//  M_AXI_GP0_awid        in   12  transaction ID, echoed on bid
//  M_AXI_GP0_awvalid     in   1   AW valid
//  M_AXI_GP0_awready     out  1   AW ready
//  M_AXI_GP0_wdata       in   32  write data
//  M_AXI_GP0_wstrb       in   4   byte strobes
//  M_AXI_GP0_wid         in   12  AXI3 write ID
//  M_AXI_GP0_wlast       in   1   last beat marker
//  M_AXI_GP0_wvalid      in   1   W valid
//  M_AXI_GP0_wready      out  1   W ready
//  M_AXI_GP0_bid         out  12  response ID
//  M_AXI_GP0_bresp       out  2   2'b00 OKAY / 2'b10 SLVERR
//  M_AXI_GP0_bvalid      out  1   B valid
//  M_AXI_GP0_bready      in   1   B ready
//  s_data                out  32  stream word (FIFO head)
//  s_last                out  1   word is last beat of its burst
//  s_valid               out  1   FIFO non-empty
//  s_ready               in   1   consumer accepts word when s_valid&s_ready
//  err_sticky            out  1   set on any SLVERR; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, FIFO empty, beat counter 0, err_sticky 0. Reset mid-burst discards
//    the burst and all FIFO contents; no B response is issued for it.
//  - FSM IDLE: awready=1 (registered, low during reset, high from the first edge after rst_n rises).
//    On awvalid&awready, latch awid and awlen; set bad=!(window hit && awsize==3'b010 && awburst==2'b01).
//    Go to DATA; awready drops the next cycle.
//  - DATA: wready = !fifo_full (always 1 when bad=1; beats are drained, not stored). A beat is accepted
//    on wvalid&wready. Good txn: push {wlast_expected, wdata with bytes where wstrb=0 forced to 8'h00}.
//    wstrb!=4'hF, wid!=latched id, or wlast!=(cnt==len) sets bad for the remaining response.
//    Accepting beat cnt==len -> RESP. Counter length governs completion, not wlast. s_last is set from
//    cnt==len.
//  - RESP: bvalid=1, bid=latched id, bresp=bad?2'b10:2'b00, held stable until bready; on
//    bvalid&bready -> IDLE, err_sticky|=bad. Zero-cycle AW acceptance in the handshake cycle is not allowed.
//  - FIFO: push and pop in the same cycle keep the count unchanged, including at full or empty. A pushed
//    word is visible on s_valid the next cycle (1-cycle latency). Pointers wrap modulo FIFO_DEPTH.
//    When full, wready=0 and the beat is stalled, not dropped.
//  - Bad-txn beats never enter the FIFO. Words already pushed before bad was set stay in the FIFO.
// TESTING
//  1. AW addr 0x4000_0010, len 3, INCR, size 2, id 0x05A; 4 beats 0x11..0x44 -> 4 stream words,
//     s_last on 0x44, bresp 00, bid 0x05A
//  2. 16-beat burst with s_ready=0 -> FIFO fills; wready=0 after word 16 only if FIFO_DEPTH=16;
//     release s_ready -> all 16 words stream out in order, B after last accept
//  3. AW addr 0x5000_0000 len 1 -> 2 beats accepted with wready=1, no stream words, bresp 10, err_sticky=1
//  4. len 2 with wlast asserted on beat 1 -> 3 beats consumed, bresp 10; wstrb 4'h3 on data 0xAABBCCDD
//     -> stream word 0x0000CCDD, bresp 10
//  5. bready held 0 for 5 cycles -> bvalid/bid/bresp stable, awready stays 0, then IDLE
//  6. rst_n low mid-burst (beat 2 of 4) -> all outputs 0 asynchronously, FIFO empty; the next burst
//     completes normally

Source files
------------

// File: rtl/gp0_wr_burst_to_stream.sv
// Write-side consumer for the PS GP0 AXI3 slave port.
// Accepts one AW/W burst at a time, returns a B response, and forwards the
// payload of well-formed bursts into a ready/valid word stream through a FIFO.
module gp0_wr_burst_to_stream #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned WIN_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] M_AXI_GP0_awaddr,
  input  logic [3:0]  M_AXI_GP0_awlen,
  input  logic [2:0]  M_AXI_GP0_awsize,
  input  logic [1:0]  M_AXI_GP0_awburst,
  input  logic [11:0] M_AXI_GP0_awid,
  input  logic        M_AXI_GP0_awvalid,
  output logic        M_AXI_GP0_awready,
  input  logic [31:0] M_AXI_GP0_wdata,
  input  logic [3:0]  M_AXI_GP0_wstrb,
  input  logic [11:0] M_AXI_GP0_wid,
  input  logic        M_AXI_GP0_wlast,
  input  logic        M_AXI_GP0_wvalid,
  output logic        M_AXI_GP0_wready,
  output logic [11:0] M_AXI_GP0_bid,
  output logic [1:0]  M_AXI_GP0_bresp,
  output logic        M_AXI_GP0_bvalid,
  input  logic        M_AXI_GP0_bready,
  output logic [31:0] s_data,
  output logic        s_last,
  output logic        s_valid,
  input  logic        s_ready,
  output logic        err_sticky
);

  localparam int unsigned     PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              awready_q;
  logic [11:0]       id_q;
  logic [3:0]        len_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              bad_q, bad_d;
  logic              err_q, err_d;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic [32:0]       mem_q [FIFO_DEPTH];

  logic              aw_hs, w_hs, b_hs;
  logic              push, pop, fifo_full;
  logic              last_beat, beat_err, aw_ok;
  logic [31:0]       masked_data;

  // Address bits below the window size only select bytes inside the window.
  logic unused_addr_bits;
  assign unused_addr_bits = ^M_AXI_GP0_awaddr[WIN_BITS-1:0];

  assign M_AXI_GP0_awready = awready_q;
  assign err_sticky        = err_q;

  assign aw_hs     = M_AXI_GP0_awvalid & awready_q;
  assign w_hs      = M_AXI_GP0_wvalid & M_AXI_GP0_wready;
  assign b_hs      = M_AXI_GP0_bvalid & M_AXI_GP0_bready;
  assign last_beat = (cnt_q == len_q);
  assign fifo_full = (count_q == DEPTH_CNT);
  assign push      = w_hs & ~bad_q;
  assign pop       = s_valid & s_ready;

  // A burst is good only if it hits the window and is 32-bit INCR.
  assign aw_ok = (M_AXI_GP0_awaddr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]) &&
                 (M_AXI_GP0_awsize == 3'b010) && (M_AXI_GP0_awburst == 2'b01);

  // Any malformed beat poisons the rest of the burst; beat count still governs completion.
  assign beat_err = (M_AXI_GP0_wstrb != 4'hF) || (M_AXI_GP0_wid != id_q) ||
                    (M_AXI_GP0_wlast != last_beat);

  // Zero out disabled byte lanes before the word enters the FIFO.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    masked_data = '0;
    for (int b = 0; b < 4; b++) begin
      masked_data[8*b +: 8] = M_AXI_GP0_wstrb[b] ? M_AXI_GP0_wdata[8*b +: 8] : 8'h00;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic: one transaction at a time, IDLE -> DATA -> RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (aw_hs)              state_d = ST_DATA;
      ST_DATA: if (w_hs && last_beat)  state_d = ST_RESP;
      ST_RESP: if (b_hs)               state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: W stalls only on a full FIFO for good bursts; B holds until bready.
  always_comb begin
    M_AXI_GP0_wready = 1'b0;
    M_AXI_GP0_bvalid = 1'b0;
    M_AXI_GP0_bid    = '0;
    M_AXI_GP0_bresp  = 2'b00;
    unique case (state_q)
      ST_DATA: M_AXI_GP0_wready = bad_q | ~fifo_full;
      ST_RESP: begin
        M_AXI_GP0_bvalid = 1'b1;
        M_AXI_GP0_bid    = id_q;
        M_AXI_GP0_bresp  = bad_q ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  // Next values for the per-transaction bookkeeping.
  always_comb begin
    cnt_d = cnt_q;
    bad_d = bad_q;
    err_d = err_q;
    if (aw_hs) begin
      cnt_d = '0;
      bad_d = ~aw_ok;
    end else if (w_hs) begin
      cnt_d = cnt_q + 4'd1;
      bad_d = bad_q | beat_err;
    end
    if (b_hs) err_d = err_q | bad_q;
  end

  // Transaction registers; awready is registered and tracks the state we are entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      bad_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      awready_q <= (state_d == ST_IDLE);
      cnt_q     <= cnt_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
      if (aw_hs) begin
        id_q  <= M_AXI_GP0_awid;
        len_q <= M_AXI_GP0_awlen;
      end
    end
  end

  // FIFO occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage holds {last, data}; the beat counter, not wlast, marks the last word.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    if (push) mem_q[wr_ptr_q] <= {last_beat, masked_data};
  end

  // Stream outputs are forced to zero whenever the FIFO is empty.
  assign s_valid = (count_q != '0);
  assign {s_last, s_data} = s_valid ? mem_q[rd_ptr_q] : 33'd0;

endmodule
